// File: rtl/seq_prim_pkg.sv
// Shared types and constants for the storage-primitive bank.
// Holds the JK command encoding and the reset value of every stored bit.
package seq_prim_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_t;

  localparam logic Q_RESET_VAL = 1'b0;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop, rising-edge clock, async active-high reset.
module jk_cell
  import seq_prim_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  jk_cmd_t cmd;
  logic    state_q;
  logic    state_d;

  assign cmd = jk_cmd_t'({j_i, k_i});

  always_comb begin
    state_d = state_q;
    unique case (cmd)
      JK_HOLD: state_d = state_q;
      JK_CLR:  state_d = 1'b0;
      JK_SET:  state_d = 1'b1;
      JK_TOG:  state_d = ~state_q;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= Q_RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/seq_primitives_bank.sv
// SR latch, gated D latch and JK flip-flop bank, WIDTH independent lanes.
// Define SEQ_PRIM_SR_GATE_EN to add the sr_en gate on the SR latch.
module seq_primitives_bank
  import seq_prim_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
`ifdef SEQ_PRIM_SR_GATE_EN
  input  logic             sr_en,
`endif
  input  logic [WIDTH-1:0] sr_set,
  input  logic [WIDTH-1:0] sr_reset,
  output logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_qnot,
  output logic [WIDTH-1:0] sr_invalid,
  input  logic             d_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_q,
  output logic [WIDTH-1:0] d_qnot,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] jk_q,
  output logic [WIDTH-1:0] jk_qnot
);

  logic [WIDTH-1:0] sr_gate;
  logic [WIDTH-1:0] sr_act;
  logic [WIDTH-1:0] sr_both;

`ifdef SEQ_PRIM_SR_GATE_EN
  assign sr_gate = {WIDTH{sr_en}};
`else
  assign sr_gate = {WIDTH{1'b1}};
`endif

  assign sr_act  = (sr_set | sr_reset) & sr_gate;
  assign sr_both = sr_set & sr_reset & sr_gate;

  // Reset masks the forbidden flag so every qnot reads 1 during reset.
  assign sr_invalid = sr_both & {WIDTH{~reset}};
  assign sr_qnot    = ~sr_q & ~sr_invalid;
  assign d_qnot     = ~d_q;
  assign jk_qnot    = ~jk_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic sr_l;
    logic d_l;

    // Both requests high stores 0, so release from 11 is deterministic.
    always_latch begin
      if (reset) begin
        sr_l <= Q_RESET_VAL;
      end else if (sr_act[i]) begin
        sr_l <= sr_set[i] & ~sr_reset[i];
      end
    end

    always_latch begin
      if (reset) begin
        d_l <= Q_RESET_VAL;
      end else if (d_en) begin
        d_l <= d[i];
      end
    end

    assign sr_q[i] = sr_l;
    assign d_q[i]  = d_l;

    jk_cell u_jk (
      .clock (clock),
      .reset (reset),
      .j_i   (j[i]),
      .k_i   (k[i]),
      .q_o   (jk_q[i])
    );
  end

endmodule

// File: tb/tb_seq_primitives_bank.sv
// Directed table-driven bench for seq_primitives_bank (two lanes).
`timescale 1ns/1ps
module tb_seq_primitives_bank;

  localparam int W = 2;

  logic         clock = 1'b0;
  logic         reset;
`ifdef SEQ_PRIM_SR_GATE_EN
  logic         sr_en;
`endif
  logic [W-1:0] sr_set, sr_reset;
  logic [W-1:0] sr_q, sr_qnot, sr_invalid;
  logic         d_en;
  logic [W-1:0] d, d_q, d_qnot;
  logic [W-1:0] j, k, jk_q, jk_qnot;

  int total = 0;
  int bad   = 0;

  seq_primitives_bank #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef SEQ_PRIM_SR_GATE_EN
    .sr_en      (sr_en),
`endif
    .sr_set     (sr_set),
    .sr_reset   (sr_reset),
    .sr_q       (sr_q),
    .sr_qnot    (sr_qnot),
    .sr_invalid (sr_invalid),
    .d_en       (d_en),
    .d          (d),
    .d_q        (d_q),
    .d_qnot     (d_qnot),
    .j          (j),
    .k          (k),
    .jk_q       (jk_q),
    .jk_qnot    (jk_qnot)
  );

  always #125 clock = ~clock;

  typedef struct {
    logic [W-1:0] set;
    logic [W-1:0] rst;
    logic         en;
    logic [W-1:0] dv;
    logic [W-1:0] e_q;
    logic [W-1:0] e_qn;
    logic [W-1:0] e_inv;
    logic [W-1:0] e_dq;
  } vec_t;

  vec_t tbl [10];

  typedef struct {
    logic [W-1:0] jv;
    logic [W-1:0] kv;
    logic [W-1:0] e_q;
  } jk_vec_t;

  jk_vec_t jtbl [9];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, " sr_q"}, sr_q, '0);
    chk({tag, " sr_qnot"}, sr_qnot, '1);
    chk({tag, " sr_invalid"}, sr_invalid, '0);
    chk({tag, " d_q"}, d_q, '0);
    chk({tag, " d_qnot"}, d_qnot, '1);
    chk({tag, " jk_q"}, jk_q, '0);
    chk({tag, " jk_qnot"}, jk_qnot, '1);
  endtask

  initial begin
    //        set    rst    en    d      q      qn     inv    dq
    tbl[0] = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01};
    tbl[1] = '{2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
    tbl[2] = '{2'b01, 2'b00, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    tbl[3] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
    tbl[4] = '{2'b10, 2'b01, 1'b1, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    tbl[5] = '{2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    tbl[6] = '{2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
    tbl[7] = '{2'b01, 2'b10, 1'b1, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
    tbl[8] = '{2'b11, 2'b01, 1'b0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    tbl[9] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};

    jtbl[0] = '{2'b00, 2'b00, 2'b00};
    jtbl[1] = '{2'b00, 2'b11, 2'b00};
    jtbl[2] = '{2'b01, 2'b00, 2'b01};
    jtbl[3] = '{2'b11, 2'b11, 2'b10};
    jtbl[4] = '{2'b11, 2'b11, 2'b01};
    jtbl[5] = '{2'b11, 2'b11, 2'b10};
    jtbl[6] = '{2'b10, 2'b01, 2'b10};
    jtbl[7] = '{2'b00, 2'b00, 2'b10};
    jtbl[8] = '{2'b01, 2'b01, 2'b11};

    // Reset with random inputs and a running clock.
    reset = 1'b1;
`ifdef SEQ_PRIM_SR_GATE_EN
    sr_en = 1'b1;
`endif
    for (int n = 0; n < 6; n++) begin
      sr_set   = W'($urandom);
      sr_reset = W'($urandom);
      d_en     = 1'($urandom);
      d        = W'($urandom);
      j        = W'($urandom);
      k        = W'($urandom);
      #90;
      chk_all_reset("reset");
    end
    sr_set = '1; sr_reset = '1; d_en = 1'b1; d = '1; j = '1; k = '0;
    #10;
    chk_all_reset("reset_all_high");

    // Idle inputs, then release reset between edges.
    @(negedge clock);
    sr_set = '0; sr_reset = '0; d_en = 1'b0; d = '0; j = '0; k = '0;
    #20 reset = 1'b0;
    @(posedge clock); #1;
    chk_all_reset("post_release");

    // Latch tables; settle then compare.
    for (int i = 0; i < 10; i++) begin
      sr_set = tbl[i].set; sr_reset = tbl[i].rst;
      d_en = tbl[i].en; d = tbl[i].dv;
      #200;
      chk($sformatf("sr_q[%0d]", i), sr_q, tbl[i].e_q);
      chk($sformatf("sr_qnot[%0d]", i), sr_qnot, tbl[i].e_qn);
      chk($sformatf("sr_invalid[%0d]", i), sr_invalid, tbl[i].e_inv);
      chk($sformatf("d_q[%0d]", i), d_q, tbl[i].e_dq);
      chk($sformatf("d_qnot[%0d]", i), d_qnot, ~tbl[i].e_dq);
    end

    // D latch is zero-cycle transparent.
    d_en = 1'b1; d = 2'b10; #1;
    chk("d_transparent", d_q, 2'b10);
    d = 2'b01; #1;
    chk("d_follow", d_q, 2'b01);
    d_en = 1'b0; #1; d = 2'b10; #1;
    chk("d_hold", d_q, 2'b01);
    chk("d_hold_qnot", d_qnot, 2'b10);

    // JK: inputs change at negedge, no change until the next rising edge.
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      j = jtbl[i].jv; k = jtbl[i].kv;
      #1;
      if (i > 0) chk($sformatf("jk_between[%0d]", i), jk_q, jtbl[i-1].e_q);
      @(posedge clock); #1;
      chk($sformatf("jk_q[%0d]", i), jk_q, jtbl[i].e_q);
      chk($sformatf("jk_qnot[%0d]", i), jk_qnot, ~jtbl[i].e_q);
    end

    // Async reset mid-period clears everything at once.
    sr_set = 2'b11; sr_reset = 2'b00; d_en = 1'b1; d = 2'b11;
    j = 2'b00; k = 2'b00;
    @(negedge clock); #20;
    chk("pre_async_jk", jk_q, 2'b11);
    reset = 1'b1; d_en = 1'b0; sr_set = '0; #1;
    chk_all_reset("async");

    // Release just after an edge; first update is the following edge.
    j = 2'b11; k = 2'b00;
    @(posedge clock); #1 reset = 1'b0;
    #1 chk("release_hold", jk_q, 2'b00);
    @(posedge clock); #1;
    chk("release_first_edge", jk_q, 2'b11);

`ifdef SEQ_PRIM_SR_GATE_EN
    sr_en = 1'b1; sr_set = '0; sr_reset = '1; #10;
    chk("gate_clear", sr_q, 2'b00);
    sr_en = 1'b0; sr_set = '1; sr_reset = '0; #10;
    chk("gate_off_set", sr_q, 2'b00);
    sr_reset = '1; #10;
    chk("gate_off_inv", sr_invalid, 2'b00);
    sr_en = 1'b1; sr_reset = '0; #10;
    chk("gate_on_set", sr_q, 2'b11);
    sr_en = 1'b0; sr_set = '0; sr_reset = '1; #10;
    chk("gate_off_rst", sr_q, 2'b11);
    sr_en = 1'b1; sr_set = 2'b01; sr_reset = 2'b11; #10;
    chk("gate_on_inv", sr_invalid, 2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_primitives_bank.md
Name: seq_primitives_bank

Overview:
- Bank of three classic storage primitives sharing one clock and one reset: an SR latch, a gated D latch and a JK flip-flop.
- Each primitive is WIDTH bits wide, bitwise independent, and drives true and complementary outputs.
- Used as the lab's reference storage-element block. Sits below the pulse/counter logic, which consumes its Q/Qnot outputs.

Parameters:
- WIDTH, 1, number of independent bit lanes per primitive.

Ports:
- clock  input  1  JK flip-flop edge clock (rising edge); latches ignore it.
- reset  input  1  asynchronous, active-high; clears all three primitives.
- sr_set  input  WIDTH  SR latch set request per lane.
- sr_reset  input  WIDTH  SR latch reset request per lane.
- sr_q  output  WIDTH  SR latch state.
- sr_qnot  output  WIDTH  complement output of SR latch.
- sr_invalid  output  WIDTH  high while sr_set and sr_reset are both high in a lane.
- d_en  input  1  D latch gate; transparent while high.
- d  input  WIDTH  D latch data.
- d_q  output  WIDTH  D latch state.
- d_qnot  output  WIDTH  always ~d_q.
- j  input  WIDTH  JK J input.
- k  input  WIDTH  JK K input.
- jk_q  output  WIDTH  JK state.
- jk_qnot  output  WIDTH  always ~jk_q.

Behaviour:
- Reset:
  - Interface fixed: one clock (clock); reset is asynchronous and active-high (reset).
  - While reset is high: sr_q=0, d_q=0, jk_q=0; all qnot outputs=1.
  - Reset overrides every other input, including mid-transparency and mid-clock-edge.
- SR latch (level-sensitive, per lane, no clock):
  - 00 holds.
  - 10 sets q=1.
  - 01 clears q=0.
  - 11 is forbidden: q=0 and qnot=0 (NOR-latch behaviour), sr_invalid=1.
  - Release from 11 to 00 leaves q=0 (reset-dominant, deterministic).
  - Outside 11, sr_qnot = ~sr_q and sr_invalid=0.
- D latch:
  - d_en=1: d_q follows d combinationally (zero-cycle, transparent).
  - d_en=0: holds the value present at the falling edge of d_en.
- JK flip-flop, on rising edge of clock, per lane:
  - 00 hold.
  - 01 q<=0.
  - 10 q<=1.
  - 11 q<=~q.
  - Latency 1 edge; no change between edges.
- Width: all lanes independent; no cross-lane interaction.
- Simultaneous reset deassertion and clock edge: reset wins for that edge; the first valid update is the next edge.

Optional Feature:
- Macro: SEQ_PRIM_SR_GATE_EN.
- Defined:
  - Adds input sr_en (1 bit). SR inputs take effect only while sr_en=1; sr_en=0 holds the state.
  - sr_invalid is asserted only when sr_en=1 and both requests are high.
- Undefined: no sr_en port; the SR latch is always enabled.

Decomposition:
- Package seq_prim_pkg holds:
  - enum jk_cmd_t {JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11};
  - constant Q_RESET_VAL=1'b0.
- One natural sub-module: jk_cell (single-bit JK flip-flop with async reset), instantiated WIDTH times via generate.
- Latches are coded inline.

Test Plan:
- reset=1 with random inputs, clock toggling -> sr_q=d_q=jk_q=0, all qnot=1; deassert reset -> outputs unchanged until inputs act.
- SR sequence with WIDTH=1, 200 ns steps:
  - set/reset=11 -> q=0, qnot=0, invalid=1.
  - 00 -> q=0, qnot=1.
  - 10 -> q=1.
  - 01 -> q=0.
  - 11 -> q=qnot=0, invalid=1.
- D latch:
  - d_en=1, d=1 -> d_q=1 immediately.
  - d=0 -> d_q=0.
  - d_en=0 then d=1 -> d_q stays 0, d_qnot=1.
- JK, clock period 250 ns, inputs changed 250 ns apart:
  - 00 from reset -> 0.
  - 01 -> 0.
  - 10 -> 1 at next rising edge.
  - 11 -> toggles 0,1,0 on successive edges.
- Async reset asserted between clock edges while jk_q=1 -> jk_q=0 immediately without waiting for clock.
- With SEQ_PRIM_SR_GATE_EN:
  - sr_en=0, set=1 -> q holds 0.
  - sr_en=1 -> q=1.
  - sr_en=0, reset=1 -> q stays 1.
